// File: rtl/traffic_pkg.sv
// Shared light codes, controller states and the round-robin helper for the
// intersection phase scheduler.
package traffic_pkg;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_GREEN  = 2'b10;

  localparam int MAX_APPR = 8;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_GREEN,
    ST_YELLOW,
    ST_WALK
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_t;

  // Searches cur+1, cur+2, ... wrapping round to cur itself. Unused upper bits
  // of req are zero, so wrapping at MAX_APPR behaves like wrapping at N_APPR.
  function automatic rr_t next_rr(input logic [MAX_APPR-1:0] req,
                                  input logic [2:0]          cur);
    rr_t        res;
    logic [2:0] cand;
    res = '0;
    for (int k = MAX_APPR; k >= 1; k--) begin
      cand = cur + 3'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Shared phase timer: synchronous clear, enabled up-count that saturates at
// last_i, and an equality flag marking the final cycle of a phase.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         eq_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != last_i)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign eq_o  = (cnt_q == last_i);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// N-approach signal controller with a pedestrian phase: round-robin green
// selection, min/max green, yellow and all-red clearance, all outputs registered.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APPR      = 4,
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 12,
  parameter int YELLOW_TIME = 3,
  parameter int CLEAR_TIME  = 2,
  parameter int WALK_TIME   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_APPR-1:0]         req,
  input  logic                      ped_req,
  output logic [2*N_APPR-1:0]       light,
  output logic                      walk,
  output logic [$clog2(N_APPR)-1:0] phase_idx,
  output logic                      ped_pending
);

  localparam int IDX_W   = $clog2(N_APPR);
  localparam int M1      = (MAX_GREEN > WALK_TIME) ? MAX_GREEN : WALK_TIME;
  localparam int M2      = (M1 > YELLOW_TIME) ? M1 : YELLOW_TIME;
  localparam int MAX_DUR = (M2 > CLEAR_TIME) ? M2 : CLEAR_TIME;
  localparam int TW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  state_e              state_q;
  logic [IDX_W-1:0]    phase_q;
  logic [2*N_APPR-1:0] light_q;
  logic                walk_q;
  logic                ped_pending_q;
  logic                served_ped_q;

  logic [TW-1:0]       timer;
  logic [TW-1:0]       timer_last;
  logic                timer_eq;
  logic                conflict;
  logic                leave;
  logic [MAX_APPR-1:0] req_ext;
  rr_t                 rr;
  logic [IDX_W-1:0]    next_idx_d;

  function automatic logic [2*N_APPR-1:0] light_for(input logic [IDX_W-1:0] idx,
                                                    input logic [1:0]       code);
    logic [2*N_APPR-1:0] v;
    v = '0;
    for (int i = 0; i < N_APPR; i++) begin
      if (idx == IDX_W'(i)) v[2*i +: 2] = code;
    end
    return v;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    timer_last = TW'(CLEAR_TIME - 1);
    req_ext    = '0;
    req_ext[N_APPR-1:0] = req;
    unique case (state_q)
      ST_CLEAR:  timer_last = TW'(CLEAR_TIME - 1);
      ST_GREEN:  timer_last = TW'(MAX_GREEN - 1);
      ST_YELLOW: timer_last = TW'(YELLOW_TIME - 1);
      ST_WALK:   timer_last = TW'(WALK_TIME - 1);
    endcase
  end

  assign conflict   = (|(req & ~(N_APPR'(1) << phase_q))) | ped_pending_q;
  assign rr         = next_rr(req_ext, 3'(phase_q));
  assign next_idx_d = rr.found ? rr.idx[IDX_W-1:0] : '0;

  // Green ends on gap-out or max-out, but only after minimum green and only
  // when someone else is waiting; otherwise it rests.
  always_comb begin
    leave = timer_eq;
    if (state_q == ST_GREEN) begin
      leave = (timer >= TW'(MIN_GREEN - 1)) && conflict && (!req[phase_q] || timer_eq);
    end
  end

  phase_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (leave),
    .en_i  (1'b1),
    .last_i(timer_last),
    .cnt_o (timer),
    .eq_o  (timer_eq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_CLEAR;
      phase_q       <= '0;
      light_q       <= '0;
      walk_q        <= 1'b0;
      ped_pending_q <= 1'b0;
      served_ped_q  <= 1'b0;
    end else begin
      if (ped_req) ped_pending_q <= 1'b1;
      if (leave) begin
        unique case (state_q)
          ST_GREEN: begin
            state_q <= ST_YELLOW;
            light_q <= light_for(phase_q, LT_YELLOW);
          end
          ST_YELLOW, ST_WALK: begin
            state_q <= ST_CLEAR;
            light_q <= '0;
            walk_q  <= 1'b0;
          end
          ST_CLEAR: begin
            // Entering WALK overrides a same-cycle press; a press held into
            // the walk re-latches on the next edge.
            if (ped_pending_q && !served_ped_q) begin
              state_q       <= ST_WALK;
              walk_q        <= 1'b1;
              served_ped_q  <= 1'b1;
              ped_pending_q <= 1'b0;
            end else begin
              state_q      <= ST_GREEN;
              phase_q      <= next_idx_d;
              light_q      <= light_for(next_idx_d, LT_GREEN);
              served_ped_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign light       = light_q;
  assign walk        = walk_q;
  assign phase_idx   = phase_q;
  assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler: a phase/elapsed-time model
// checked every cycle, plus literal expectations at key points of each scenario.
module tb_intersection_phase_scheduler;

  localparam int N       = 4;
  localparam int MIN_G   = 4;
  localparam int MAX_G   = 12;
  localparam int YEL_T   = 3;
  localparam int CLR_T   = 2;
  localparam int WALK_T  = 6;

  localparam int K_CLEAR  = 0;
  localparam int K_GREEN  = 1;
  localparam int K_YELLOW = 2;
  localparam int K_WALK   = 3;

  typedef struct packed {
    int kind;
    int elapsed;
    int appr;
    bit ped;
    bit served;
  } mstate_t;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic           ped_req;
  logic [2*N-1:0] light;
  logic           walk;
  logic [1:0]     phase_idx;
  logic           ped_pending;

  int      checks = 0;
  int      errors = 0;
  bit      chk_en = 0;
  mstate_t m;

  intersection_phase_scheduler #(
    .N_APPR(N), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
    .YELLOW_TIME(YEL_T), .CLEAR_TIME(CLR_T), .WALK_TIME(WALK_T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ped_req    (ped_req),
    .light      (light),
    .walk       (walk),
    .phase_idx  (phase_idx),
    .ped_pending(ped_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic mstate_t reset_state();
    mstate_t s;
    s.kind = K_CLEAR; s.elapsed = 0; s.appr = 0; s.ped = 0; s.served = 0;
    return s;
  endfunction

  // One clock of the rules: elapsed counts cycles already spent in the phase.
  function automatic mstate_t model_step(mstate_t s, logic [N-1:0] r, logic p);
    mstate_t n;
    int      done;
    bit      other;
    bit      found;
    int      cand;
    n       = s;
    done    = s.elapsed + 1;
    n.elapsed = done;
    n.ped   = s.ped | p;
    other   = 0;
    for (int i = 0; i < N; i++) if (r[i] && i != s.appr) other = 1;
    case (s.kind)
      K_CLEAR: if (done == CLR_T) begin
        n.elapsed = 0;
        if (s.ped && !s.served) begin
          n.kind = K_WALK; n.served = 1; n.ped = 0;
        end else begin
          n.kind = K_GREEN; n.served = 0; n.appr = 0; found = 0;
          for (int k = 1; k <= N; k++) begin
            cand = (s.appr + k) % N;
            if (!found && r[cand]) begin n.appr = cand; found = 1; end
          end
        end
      end
      K_GREEN: if (done >= MIN_G && (other || s.ped) && (!r[s.appr] || done >= MAX_G)) begin
        n.kind = K_YELLOW; n.elapsed = 0;
      end
      K_YELLOW: if (done == YEL_T) begin n.kind = K_CLEAR; n.elapsed = 0; end
      default:  if (done == WALK_T) begin n.kind = K_CLEAR; n.elapsed = 0; end
    endcase
    return n;
  endfunction

  function automatic logic [2*N-1:0] exp_light(mstate_t s);
    logic [2*N-1:0] v;
    v = '0;
    if (s.kind == K_GREEN)  v[2*s.appr +: 2] = 2'b10;
    if (s.kind == K_YELLOW) v[2*s.appr +: 2] = 2'b01;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= reset_state();
    else        m <= model_step(m, req, ped_req);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_light", 32'(light), 32'(exp_light(m)));
      check("cmp_walk", 32'(walk), 32'(m.kind == K_WALK));
      check("cmp_phase_idx", 32'(phase_idx), 32'(m.appr));
      check("cmp_ped_pending", 32'(ped_pending), 32'(m.ped));
    end
  end

  initial begin
    reset = 1'b0; req = '0; ped_req = 1'b0;

    // Reset and startup into resting green on approach 0
    tick(5);
    chk_en = 1;
    check("rst_light", 32'(light), 32'h00);
    check("rst_walk", 32'(walk), 32'h0);
    check("rst_idx", 32'(phase_idx), 32'h0);
    check("rst_ped", 32'(ped_pending), 32'h0);
    reset = 1'b1;
    tick(1); check("startup_clear", 32'(light), 32'h00);
    tick(1); check("startup_green", 32'(light), 32'h02);
    check("startup_idx", 32'(phase_idx), 32'h0);
    tick(50); check("rest_green", 32'(light), 32'h02);

    // Gap-out to approach 2
    req = 4'b0100;
    tick(1); check("s2_yellow0", 32'(light), 32'h01);
    tick(2); check("s2_yellow2", 32'(light), 32'h01);
    tick(1); check("s2_clear0", 32'(light), 32'h00);
    tick(1); check("s2_clear1", 32'(light), 32'h00);
    tick(1); check("s2_green2", 32'(light), 32'h20);
    check("s2_idx", 32'(phase_idx), 32'h2);
    req = 4'b0000;
    tick(5); check("s2_rest_nonhome", 32'(light), 32'h20);

    // Back to approach 0, then max-out alternation between 0 and 1
    req = 4'b0001;
    tick(6); check("s3_green0", 32'(light), 32'h02);
    req = 4'b0011;
    tick(11); check("s3_green0_last", 32'(light), 32'h02);
    tick(1);  check("s3_maxout0", 32'(light), 32'h01);
    tick(2);  check("s3_yellow0", 32'(light), 32'h01);
    tick(2);  check("s3_clear", 32'(light), 32'h00);
    tick(1);  check("s3_green1", 32'(light), 32'h08);
    check("s3_idx1", 32'(phase_idx), 32'h1);
    tick(11); check("s3_green1_last", 32'(light), 32'h08);
    tick(1);  check("s3_maxout1", 32'(light), 32'h04);
    tick(5);  check("s3_green0_again", 32'(light), 32'h02);
    check("s3_idx0", 32'(phase_idx), 32'h0);
    req = 4'b0000;

    // Single pedestrian press with no vehicles
    tick(5);
    ped_req = 1'b1;
    tick(1); ped_req = 1'b0;
    check("s4_pending", 32'(ped_pending), 32'h1);
    check("s4_still_green", 32'(light), 32'h02);
    tick(1); check("s4_yellow", 32'(light), 32'h01);
    tick(2); tick(2);
    tick(1); check("s4_walk", 32'(walk), 32'h1);
    check("s4_walk_red", 32'(light), 32'h00);
    check("s4_pending_clr", 32'(ped_pending), 32'h0);
    tick(5); check("s4_walk_last", 32'(walk), 32'h1);
    tick(1); check("s4_walk_end", 32'(walk), 32'h0);
    tick(1); check("s4_clear", 32'(light), 32'h00);
    tick(1); check("s4_green0", 32'(light), 32'h02);

    // Pedestrian and approach 3 together; second press waits for a vehicle green
    tick(10);
    ped_req = 1'b1; req = 4'b1000;
    tick(1); ped_req = 1'b0;
    check("s5_yellow", 32'(light), 32'h01);
    tick(4);
    tick(1); check("s5_walk_first", 32'(walk), 32'h1);
    ped_req = 1'b1;
    tick(1); ped_req = 1'b0;
    check("s5_repress", 32'(ped_pending), 32'h1);
    tick(4);
    tick(3); check("s5_green3", 32'(light), 32'h80);
    check("s5_idx3", 32'(phase_idx), 32'h3);
    check("s5_walk_deferred", 32'(walk), 32'h0);
    tick(5); check("s5_green3_held", 32'(light), 32'h80);
    req = 4'b0000;
    tick(1); check("s5_yellow3", 32'(light), 32'h40);
    tick(4);
    tick(1); check("s5_walk_second", 32'(walk), 32'h1);
    tick(5);
    tick(3); check("s5_green0", 32'(light), 32'h02);

    // Asynchronous reset in the middle of yellow
    tick(5);
    req = 4'b0010;
    tick(1); check("s6_yellow", 32'(light), 32'h01);
    #2 reset = 1'b0;
    #1;
    check("s6_async_light", 32'(light), 32'h00);
    check("s6_async_walk", 32'(walk), 32'h0);
    check("s6_async_idx", 32'(phase_idx), 32'h0);
    @(negedge clk);
    req = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(1); check("s6_clear", 32'(light), 32'h00);
    tick(1); check("s6_green0", 32'(light), 32'h02);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Schedules green time for an N-approach signalised intersection plus one pedestrian crossing phase.
- Arbitrates between vehicle-sensor requesters round-robin.
- Enforces min/max green, yellow and all-red clearance timing.
- Drives one 2-bit light code per approach.
- Generalises the two-road highway/country controller to N approaches; approach 0 is the home (highway) approach, which rests in green.

Parameters:
N_APPR, 4, number of vehicle approaches (2..8)
MIN_GREEN, 4, minimum green duration in cycles (>=1)
MAX_GREEN, 12, green duration at max-out when a conflicting request is pending (>=MIN_GREEN)
YELLOW_TIME, 3, yellow duration in cycles (>=1)
CLEAR_TIME, 2, all-red clearance duration in cycles (>=1)
WALK_TIME, 6, pedestrian walk duration in cycles (>=1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  N_APPR  level vehicle-present sensors, bit i = approach i
ped_req  input  1  pedestrian button, any-width pulse
light  output  2*N_APPR  light code of approach i at [2i+1:2i]
walk  output  1  pedestrian walk indication
phase_idx  output  clog2(N_APPR)  approach currently green or yellow, else last served
ped_pending  output  1  latched pedestrian request not yet served

Behaviour:
- Light codes: RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 never driven.
- States: CLEAR, GREEN, YELLOW, WALK.
- Timer: one shared counter, cleared on every state entry. A state of duration D exits on the edge where timer==D-1, so it lasts exactly D cycles. In GREEN the timer saturates at MAX_GREEN-1.
- Outputs are Moore, registered, and change on the same edge as the state.
  - GREEN/YELLOW: light[phase_idx] shows GREEN/YELLOW; all other approaches RED.
  - CLEAR and WALK: all approaches RED.
  - walk=1 only in WALK.
- Reset asserted (async): state=CLEAR, timer=0, phase_idx=0, all RED, walk=0, ped_pending=0, served_ped=0. After release, CLEAR runs CLEAR_TIME cycles.
- ped_pending: set on any cycle ped_req=1; cleared on entry to WALK. A press during WALK sets it again on the following cycle for a later service.
- Conflict: (req & ~(1<<phase_idx)) != 0, or ped_pending.
- GREEN exit to YELLOW, only when timer>=MIN_GREEN-1 and conflict is true, and either:
  - req[phase_idx]==0 (gap-out), or
  - timer==MAX_GREEN-1 (max-out).
  With no conflict, GREEN is held indefinitely (rest in green), including on non-home approaches.
- YELLOW -> CLEAR after YELLOW_TIME cycles.
- CLEAR exit selection, first match wins:
  1. ped_pending && !served_ped: go to WALK and set served_ped.
  2. Round-robin search of req from phase_idx+1 upward with wrap-around, ending at phase_idx itself: first set bit becomes GREEN, phase_idx updated, served_ped cleared.
  3. No requests: GREEN on approach 0.
- WALK -> CLEAR after WALK_TIME cycles. served_ped guarantees at least one vehicle green between walks, so pedestrians cannot starve vehicles.
- req sampled only at decision edges. A request withdrawn before selection is simply not served; no request latching for vehicles.
- Reset mid-phase: immediate all-RED, no yellow, then the normal CLEAR startup.

Decomposition:
- Package traffic_pkg holds:
  - light code constants RED/YELLOW/GREEN;
  - state enum (CLEAR, GREEN, YELLOW, WALK);
  - the function next_rr(req, cur), returning the round-robin winner index plus a found flag.
- Sub-module phase_timer: loadable clear, enable, saturating up-counter with a compare-equal output against a duration input; width clog2 of the largest duration parameter.

Test Plan:
(All scenarios use default parameters.)
1. Reset low 5 cycles, req=0, ped_req=0: all RED. Release gives 2 cycles all-RED, then light[1:0]=GREEN, phase_idx=0, held for 50 cycles.
2. Approach 0 green for 10 cycles, req=4'b0100 raised: next edge light[1:0]=YELLOW for 3 cycles, all-RED 2, then light[5:4]=GREEN, phase_idx=2.
3. req=4'b0011 held constant from reset: approach 0 GREEN exactly 12 cycles, Y3, R2; approach 1 GREEN 12 cycles, Y3, R2; approach 0 GREEN again.
4. 1-cycle ped_req during approach-0 green, req=0: ped_pending=1; Y3, R2; walk=1 for 6 cycles with all RED and ped_pending=0; R2; approach 0 GREEN.
5. ped_req and req[3] in the same cycle during approach-0 green: WALK served first, then approach 3 GREEN. A second ped_req during that walk is served only after approach 3's green.
6. reset asserted mid-YELLOW between clock edges: light and walk go all RED/0 without waiting for clk. After release, 2 cycles CLEAR, then approach 0 GREEN.
